// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/step/breakpoint controller gating a CPU datapath clock enable
module cpu_step_ctrl #(
    parameter int          DEB_LEN    = 4,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] BP_ADDR    = 32'h0000_0020
) (
    input  logic        mainClock,
    input  logic        reset,
    input  logic [3:0]  SWITCH,
    input  logic        step_btn,
    input  logic [31:0] pc,
    input  logic        halt_insn,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic [2:0]  ctrl_state,
    output logic [15:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_STEP  = 3'd2,
        S_RUN   = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam int DEB_W  = (DEB_LEN > 1) ? $clog2(DEB_LEN + 1) : 1;
    localparam int INIT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    state_t            state;
    state_t            state_next;
    logic [2:0]        sw_meta;
    logic [2:0]        sw_sync;
    logic              btn_meta;
    logic              btn_sync;
    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_level;
    logic              deb_prev;
    logic              sw2_prev;
    logic [INIT_W-1:0] init_cnt;
    logic [1:0]        mode;
    logic              step_req;
    logic              soft_req;
    logic              stop_cond;
    logic              unused_sw3;

    // SWITCH[3] carries no function
    assign unused_sw3 = SWITCH[3];

    // two-flop synchronisers for the asynchronous switch and button inputs
    always_ff @(posedge mainClock) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= SWITCH[2:0];
            sw_sync  <= sw_meta;
            btn_meta <= step_btn;
            btn_sync <= btn_meta;
        end
    end

    // debounce: flip the level after DEB_LEN consecutive disagreeing samples
    always_ff @(posedge mainClock) begin
        if (reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (btn_sync != deb_level) begin
            if (deb_cnt == DEB_W'(DEB_LEN - 1)) begin
                deb_level <= btn_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // previous-cycle copies used for rising-edge pulse generation
    always_ff @(posedge mainClock) begin
        if (reset) begin
            deb_prev <= 1'b0;
            sw2_prev <= 1'b0;
        end else begin
            deb_prev <= deb_level;
            sw2_prev <= sw_sync[2];
        end
    end

    assign step_req  = deb_level & ~deb_prev;
    assign soft_req  = sw_sync[2] & ~sw2_prev;
    assign mode      = sw_sync[1:0];
    assign stop_cond = halt_insn | ((mode == 2'b11) && (pc == BP_ADDR));

    // state register
    always_ff @(posedge mainClock) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // INIT dwell counter; restarts whenever INIT is (re)entered
    always_ff @(posedge mainClock) begin
        if (reset || soft_req || (state != S_INIT)) begin
            init_cnt <= '0;
        end else begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // next-state and clock-enable decode; soft reset overrides everything
    always_comb begin
        state_next = state;
        cpu_en     = 1'b0;
        case (state)
            S_INIT: begin
                if (init_cnt == INIT_W'(RST_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (mode[1]) begin
                    state_next = S_RUN;
                end else if ((mode == 2'b01) && step_req) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                cpu_en     = 1'b1;
                state_next = S_IDLE;
            end
            S_RUN: begin
                cpu_en = ~stop_cond;
                if (!mode[1]) begin
                    state_next = S_IDLE;
                end else if (stop_cond) begin
                    state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (mode == 2'b00) begin
                    state_next = S_IDLE;
                end else if (step_req) begin
                    state_next = S_STEP;
                end
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
        if (soft_req) begin
            state_next = S_INIT;
        end
    end

    // committed-instruction counter, cleared in INIT, wraps naturally
    always_ff @(posedge mainClock) begin
        if (reset || (state == S_INIT)) begin
            instr_cnt <= '0;
        end else if (cpu_en) begin
            instr_cnt <= instr_cnt + 16'd1;
        end
    end

    assign cpu_rst    = (state == S_INIT);
    assign ctrl_state = state;

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEB_LEN, default 4: consecutive cycles step_btn must hold a new level before it is accepted.
REQ-002 Parameter RST_CYCLES, default 4: cycles cpu_rst is held after reset or soft reset.
REQ-003 Parameter BP_ADDR, default 32'h0000_0020: breakpoint PC.
REQ-004 Port mainClock, input, 1: single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port SWITCH, input, 4: [1:0] mode (00 HALT, 01 STEP, 10 RUN, 11 RUN_BP); [2] soft reset; [3] reserved and ignored.
REQ-007 Port step_btn, input, 1: raw, asynchronous single-step button.
REQ-008 Port pc, input, 32: current CPU program counter.
REQ-009 Port halt_insn, input, 1: decoder flag; the instruction at pc is HALT.
REQ-010 Port cpu_en, output, 1: CPU datapath clock enable; the CPU commits one instruction per mainClock edge where cpu_en=1.
REQ-011 Port cpu_rst, output, 1: CPU datapath reset.
REQ-012 Port ctrl_state, output, 3: state code (INIT=0, IDLE=1, STEP=2, RUN=3, BREAK=4).
REQ-013 Port instr_cnt, output, 16: count of cycles in which cpu_en=1.

Function
REQ-014 SWITCH and step_btn shall each pass through a 2-flop synchroniser; all logic shall use only the synchronised values.
REQ-015 Debounce: the debounced step level shall flip on the DEB_LEN-th consecutive edge at which the synchronised value differs from it; any agreeing sample shall clear the count.
REQ-016 step_req shall be a one-cycle pulse on each 0->1 transition of the debounced level; a held button shall yield exactly one pulse.
REQ-017 soft_req shall be a one-cycle pulse on each 0->1 transition of synchronised SWITCH[2].
REQ-018 soft_req shall force state INIT from any state and shall override every other transition in that cycle.
REQ-019 INIT shall last exactly RST_CYCLES cycles, then go to IDLE.
REQ-020 IDLE: mode 10 or 11 -> RUN; mode 01 with step_req -> STEP; otherwise stay.
REQ-021 STEP shall last exactly one cycle with cpu_en=1, regardless of halt_insn or breakpoint, then go to IDLE.
REQ-022 RUN, in priority order: mode 00 or 01 -> IDLE; stop_cond -> BREAK; otherwise stay.
REQ-023 stop_cond = halt_insn OR (mode==11 AND pc==BP_ADDR), evaluated combinationally in the current cycle.
REQ-024 BREAK, in priority order: mode 00 -> IDLE; step_req -> STEP; otherwise stay.
REQ-025 cpu_en shall be combinational: 1 in STEP; 1 in RUN when stop_cond=0; 0 otherwise.
REQ-026 The instruction at which stop_cond becomes true shall not be executed (zero-latency gating).
REQ-027 cpu_rst shall equal (state==INIT); cpu_en shall be 0 whenever cpu_rst=1.
REQ-028 instr_cnt shall increment by 1 on each edge with cpu_en=1.
REQ-029 instr_cnt shall wrap from 16'hFFFF to 0 and shall clear to 0 while in INIT.
REQ-030 Step after BREAK, in RUN or RUN_BP mode: STEP executes the stopped instruction, then IDLE, then RUN on the following cycle.
REQ-031 If step_req coincides with a mode change, the mode priority of REQ-020/022/024 shall decide the transition.
REQ-032 A step_req that causes no transition shall be discarded, not queued.

Reset
REQ-033 While reset=1 the block shall enter INIT; on release INIT shall then run for RST_CYCLES cycles.
REQ-034 While reset=1: INIT counter=0, instr_cnt=0, synchronisers=0, debounce count=0, debounced level=0.
REQ-035 Outputs while reset=1: cpu_rst=1, cpu_en=0, ctrl_state=0, instr_cnt=0.
REQ-036 reset asserted mid-operation (RUN, STEP or BREAK) shall abort the operation and behave identically to REQ-033..035.

Verification
REQ-037 reset high 3 cycles, SWITCH=0000 -> cpu_rst=1 for 4 cycles after release, then ctrl_state=1, cpu_en=0, instr_cnt=0.
REQ-038 SWITCH=0001, step_btn high 20 cycles -> one cpu_en pulse within 2+DEB_LEN+2 cycles, instr_cnt=1; a 2-cycle glitch -> no pulse.
REQ-039 SWITCH=0010, pc incrementing by 4 from 0 -> cpu_en=1 every cycle; halt_insn=1 at pc=0x10 -> cpu_en=0 that cycle, ctrl_state=4, instr_cnt=4.
REQ-040 SWITCH=0011, pc from 0 -> stop at pc=0x20 with instr_cnt=8; step press -> pc=0x24, then RUN resumes.
REQ-041 RUN at instr_cnt=16'hFFFE -> wraps to 0 after 2 more cycles; SWITCH[2] 0->1 -> INIT, cpu_rst=1 for 4 cycles, instr_cnt=0.
